ps2_key_ctrl: RTL and testbench

Consumer/sequencer for the PS/2 keyboard scan-code FIFO. Pops bytes with the FIFO's read strobe and parses Set-2 prefixes (E0, F0, E1). Maintains held/released state for the two tank players' control keys and emits per-key event pulses to game logic. Sits between the PS/2 receiver and the tank movement/fire logic.

---
 rtl/ps2_key_ctrl_if.sv | 18 +
 rtl/ps2_key_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_ctrl_if.sv
// Scan-code FIFO link between the PS/2 receiver FIFO and the key controller.
//
// Handshake: kb_ready is the FIFO's "valid" (non-empty) and kb_data is its head
// byte, stable while kb_ready=1. The consumer takes a byte by driving kb_rdn low
// for exactly one clk cycle; the FIFO pops on the rising edge that ends that
// cycle and presents its new head (and kb_ready) from the following cycle on.
// kb_overflow is a level flag from the FIFO meaning bytes were lost.
interface ps2_key_ctrl_if;
   logic       kb_ready;
   logic [7:0] kb_data;
   logic       kb_overflow;
   logic       kb_rdn;

   // FIFO side
   modport master (output kb_ready, output kb_data, output kb_overflow, input kb_rdn);
   // key controller side
   modport slave  (input kb_ready, input kb_data, input kb_overflow, output kb_rdn);
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops Set-2 scan codes from the PS/2 FIFO, tracks E0/F0/E1 prefix
// state and keeps held/released state for both tank players' control keys.
// One byte costs three cycles: IDLE (latch head), POP (strobe), PARSE (decode).
module ps2_key_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int PAUSE_SKIP     = 7
) (
   input  logic          clk,
   input  logic          rst,
   ps2_key_ctrl_if.slave kb,
   output logic [4:0]    p1_keys,
   output logic [4:0]    p2_keys,
   output logic          p1_fire_pulse,
   output logic          p2_fire_pulse,
   output logic          key_valid,
   output logic [8:0]    key_code,
   output logic          key_break,
   output logic          ovf_pulse,
   output logic [1:0]    fsm_state
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int SW = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;
   localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] SKIP_LOAD = SW'(PAUSE_SKIP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POP   = 2'd1,
      S_PARSE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic [SW-1:0] skip_q, skip_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [4:0]    p1_d, p2_d;
   logic          rdn_d;
   logic          kv_d;
   logic [8:0]    code_d;
   logic          kbrk_d;
   logic          p1f_d, p2f_d;
   logic          ovf_d;
   logic          make_w;

   assign fsm_state = state_q;
   assign make_w    = ~brk_q;

   // Next-state, prefix tracking, key-bit update and output pulse generation.
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      skip_d  = skip_q;
      tcnt_d  = tcnt_q;
      p1_d    = p1_keys;
      p2_d    = p2_keys;
      rdn_d   = 1'b1;
      kv_d    = 1'b0;
      code_d  = key_code;
      kbrk_d  = key_break;
      p1f_d   = 1'b0;
      p2f_d   = 1'b0;
      ovf_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A prefix waiting on an empty FIFO is abandoned after the timeout.
            if ((ext_q || brk_q) && !kb.kb_ready) begin
               if (tcnt_q == T_LAST) begin
                  ext_d  = 1'b0;
                  brk_d  = 1'b0;
                  tcnt_d = '0;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            // Lost bytes may include break codes, so release everything.
            if (kb.kb_overflow) begin
               p1_d   = '0;
               p2_d   = '0;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
               skip_d = '0;
               tcnt_d = '0;
               ovf_d  = 1'b1;
            end
            if (kb.kb_ready) begin
               byte_d  = kb.kb_data;
               tcnt_d  = '0;
               rdn_d   = 1'b0;
               state_d = S_POP;
            end
         end

         S_POP: begin
            state_d = S_PARSE;
         end

         S_PARSE: begin
            state_d = S_IDLE;
            if (skip_q != '0) begin
               skip_d = skip_q - SW'(1);
            end else if (byte_q == 8'hE1) begin
               skip_d = SKIP_LOAD;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
            end else if (byte_q == 8'hE0) begin
               ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
               brk_d = 1'b1;
            end else if (byte_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                        8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
               // Keyboard status/ack bytes: not key events, and they end any prefix.
               ext_d = 1'b0;
               brk_d = 1'b0;
            end else begin
               kv_d   = 1'b1;
               code_d = {ext_q, byte_q};
               kbrk_d = brk_q;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
               if (!ext_q) begin
                  case (byte_q)
                     8'h1D: p1_d[0] = make_w;
                     8'h1B: p1_d[1] = make_w;
                     8'h1C: p1_d[2] = make_w;
                     8'h23: p1_d[3] = make_w;
                     8'h29: begin
                        p1_d[4] = make_w;
                        p1f_d   = make_w & ~p1_keys[4];
                     end
                     8'h5A: begin
                        p2_d[4] = make_w;
                        p2f_d   = make_w & ~p2_keys[4];
                     end
                     default: ;
                  endcase
               end else begin
                  case (byte_q)
                     8'h75: p2_d[0] = make_w;
                     8'h72: p2_d[1] = make_w;
                     8'h6B: p2_d[2] = make_w;
                     8'h74: p2_d[3] = make_w;
                     8'h5A: begin
                        p2_d[4] = make_w;
                        p2f_d   = make_w & ~p2_keys[4];
                     end
                     default: ;
                  endcase
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over everything, including a pop in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         byte_q        <= '0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         skip_q        <= '0;
         tcnt_q        <= '0;
         kb.kb_rdn     <= 1'b1;
         p1_keys       <= '0;
         p2_keys       <= '0;
         p1_fire_pulse <= 1'b0;
         p2_fire_pulse <= 1'b0;
         key_valid     <= 1'b0;
         key_code      <= '0;
         key_break     <= 1'b0;
         ovf_pulse     <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         ext_q         <= ext_d;
         brk_q         <= brk_d;
         skip_q        <= skip_d;
         tcnt_q        <= tcnt_d;
         kb.kb_rdn     <= rdn_d;
         p1_keys       <= p1_d;
         p2_keys       <= p2_d;
         p1_fire_pulse <= p1f_d;
         p2_fire_pulse <= p2f_d;
         key_valid     <= kv_d;
         key_code      <= code_d;
         key_break     <= kbrk_d;
         ovf_pulse     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: a queue-backed FIFO feeds scan codes, a byte-level
// reference model predicts key events, and a monitor checks them as they appear.
module tb_ps2_key_ctrl;

   localparam int T = 200;
   localparam int SKIP = 7;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] p1_keys, p2_keys;
   logic       p1_fire_pulse, p2_fire_pulse;
   logic       key_valid;
   logic [8:0] key_code;
   logic       key_break;
   logic       ovf_pulse;
   logic [1:0] fsm_state;

   ps2_key_ctrl_if kb ();

   ps2_key_ctrl #(.TIMEOUT_CYCLES(T), .PAUSE_SKIP(SKIP)) dut (
      .clk           (clk),
      .rst           (rst),
      .kb            (kb),
      .p1_keys       (p1_keys),
      .p2_keys       (p2_keys),
      .p1_fire_pulse (p1_fire_pulse),
      .p2_fire_pulse (p2_fire_pulse),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .key_break     (key_break),
      .ovf_pulse     (ovf_pulse),
      .fsm_state     (fsm_state)
   );

   // clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int pushed = 0;

   // ---------------- FIFO model ----------------
   logic [7:0] fifo_q[$];
   bit         pop_req = 1'b0;

   initial begin : fifo_proc
      kb.kb_ready = 1'b0;
      kb.kb_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (pop_req) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
         end
         kb.kb_ready = (fifo_q.size() != 0);
         kb.kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      end
   end

   // ---------------- reference model ----------------
   // Expected item: {ovf, p1_fire, p2_fire, p1_keys, p2_keys, key_break, key_code}
   logic [22:0] exp_q[$];
   logic [4:0]  m_p1 = '0;
   logic [4:0]  m_p2 = '0;
   bit          m_ext = 1'b0;
   bit          m_brk = 1'b0;
   int          m_skip = 0;
   logic [8:0]  m_last_code = '0;
   bit          m_last_brk = 1'b0;

   // Player/bit a key maps to: 0..4 player 1, 5..9 player 2, -1 unmapped.
   function automatic int key_idx(input bit e, input logic [7:0] c);
      if (!e) begin
         case (c)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            8'h29: return 4;
            8'h5A: return 9;
            default: return -1;
         endcase
      end
      case (c)
         8'h75: return 5;
         8'h72: return 6;
         8'h6B: return 7;
         8'h74: return 8;
         8'h5A: return 9;
         default: return -1;
      endcase
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int idx;
      bit f1, f2;
      if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE1) begin
         m_skip = SKIP;
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
         m_ext = 0;
         m_brk = 0;
      end else begin
         idx = key_idx(m_ext, b);
         f1 = (idx == 4) && !m_brk && !m_p1[4];
         f2 = (idx == 9) && !m_brk && !m_p2[4];
         if (idx >= 0 && idx < 5) m_p1[idx] = !m_brk;
         else if (idx >= 5) m_p2[idx-5] = !m_brk;
         m_last_code = {m_ext, b};
         m_last_brk  = m_brk;
         exp_q.push_back({1'b0, f1, f2, m_p1, m_p2, m_last_brk, m_last_code});
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] b);
      fifo_q.push_back(b);
      pushed++;
      model_byte(b);
   endtask

   task automatic send_key(input bit e, input logic [7:0] c, input bit brk);
      if (e) send(8'hE0);
      if (brk) send(8'hF0);
      send(c);
   endtask

   task automatic send_pause();
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
   endtask

   task automatic drain();
      int quiet = 0;
      int budget = 0;
      while (quiet < 6 && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (fifo_q.size() == 0 && kb.kb_ready === 1'b0) quiet++;
         else quiet = 0;
      end
      checks++;
      if (quiet < 6) begin
         errors++;
         $display("FAIL drain_budget fifo_left=%0d required=0", fifo_q.size());
      end
   endtask

   task automatic idle_timeout();
      drain();
      repeat (2 * T + 10) @(negedge clk);
      m_ext = 0;
      m_brk = 0;
   endtask

   task automatic overflow();
      drain();
      kb.kb_overflow = 1'b1;
      m_p1 = '0;
      m_p2 = '0;
      m_ext = 0;
      m_brk = 0;
      m_skip = 0;
      exp_q.push_back({1'b1, 2'b00, 10'd0, m_last_brk, m_last_code});
      @(negedge clk);
      kb.kb_overflow = 1'b0;
   endtask

   function automatic logic [8:0] pick_key(input int i);
      case (i)
         0:  return 9'h029;
         1:  return 9'h023;
         2:  return 9'h01C;
         3:  return 9'h01B;
         4:  return 9'h01D;
         5:  return 9'h05A;
         6:  return 9'h15A;
         7:  return 9'h174;
         8:  return 9'h16B;
         9:  return 9'h172;
         10: return 9'h175;
         11: return 9'h015;
         12: return 9'h11F;
         default: return 9'h075;
      endcase
   endfunction

   function automatic logic [7:0] pick_ignored(input int i);
      case (i)
         0: return 8'h00;
         1: return 8'hAA;
         2: return 8'hEE;
         3: return 8'hFA;
         4: return 8'hFC;
         5: return 8'hFD;
         6: return 8'hFE;
         default: return 8'hFF;
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      int cyc = 0;
      int last_pop = -100;
      logic [22:0] got, e;
      forever begin
         @(negedge clk);
         pop_req = (kb.kb_rdn === 1'b0);
         if (rst !== 1'b1) begin
            cyc++;
            if (kb.kb_rdn === 1'b0) begin
               if (last_pop >= 0) begin
                  checks++;
                  if (cyc - last_pop < 3) begin
                     errors++;
                     $display("FAIL pop_gap got=%0d required>=3", cyc - last_pop);
                  end
               end
               last_pop = cyc;
            end
            if (key_valid === 1'b1 || ovf_pulse === 1'b1) begin
               got = {ovf_pulse, p1_fire_pulse, p2_fire_pulse, p1_keys, p2_keys, key_break, key_code};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_event got=%h required=none", got);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     errors++;
                     $display("FAIL event got=%h required=%h", got, e);
                  end
               end
            end else if (p1_fire_pulse !== 1'b0 || p2_fire_pulse !== 1'b0) begin
               errors++;
               $display("FAIL stray_fire got=%b%b required=00", p1_fire_pulse, p2_fire_pulse);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : main
      logic [8:0] k;
      rst = 1'b1;
      kb.kb_overflow = 1'b0;
      // Byte already waiting while reset is held: it must not be popped yet.
      send(8'h1D);
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (kb.kb_rdn !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdn got=%b required=1", kb.kb_rdn);
         end
         checks++;
         if ({p1_keys, p2_keys, p1_fire_pulse, p2_fire_pulse, key_valid, key_code, key_break, ovf_pulse} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0",
                     {p1_keys, p2_keys, p1_fire_pulse, p2_fire_pulse, key_valid, key_code, key_break, ovf_pulse});
         end
      end
      checks++;
      if (pops != 0) begin
         errors++;
         $display("FAIL reset_pops got=%0d required=0", pops);
      end
      rst = 1'b0;

      // P1 up make (byte queued during reset) and break
      send(8'hF0); send(8'h1D);
      drain();
      // extended P2 sequence
      send_key(1, 8'h75, 0);
      send_key(1, 8'h6B, 0);
      send_key(1, 8'h75, 1);
      drain();
      // fire edge and typematic repeat
      send(8'h29); send(8'h29); send(8'h29); send_key(0, 8'h29, 1);
      drain();
      // abandoned prefix, then a plain 75
      send(8'hE0);
      idle_timeout();
      send(8'h75);
      // Pause sequence, then a normal key
      send_pause();
      send(8'h1D);
      drain();
      // overflow with keys held and a pending break prefix
      send_key(1, 8'h75, 0);
      send(8'hF0);
      overflow();
      send(8'h1D);
      drain();

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r <= 12) begin
            k = pick_key($urandom_range(0, 13));
            send_key(k[8], k[7:0], $urandom_range(0, 2) == 0);
         end else if (r == 13) begin
            send(pick_ignored($urandom_range(0, 7)));
         end else if (r == 14) begin
            send_pause();
         end else if (r <= 16) begin
            drain();
            repeat ($urandom_range(0, 10)) @(negedge clk);
         end else if (r == 17) begin
            send($urandom_range(0, 1) ? 8'hE0 : 8'hF0);
            idle_timeout();
         end else if (r == 18) begin
            overflow();
         end else begin
            send($urandom_range(0, 1) ? 8'hE0 : 8'hF0);
            send(pick_ignored($urandom_range(0, 7)));
         end
      end

      drain();
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL events_left got=%0d required=0", exp_q.size());
      end
      checks++;
      if (pops != pushed) begin
         errors++;
         $display("FAIL pop_count got=%0d required=%0d", pops, pushed);
      end
      checks++;
      if (p1_keys !== m_p1) begin
         errors++;
         $display("FAIL final_p1 got=%b required=%b", p1_keys, m_p1);
      end
      checks++;
      if (p2_keys !== m_p2) begin
         errors++;
         $display("FAIL final_p2 got=%b required=%b", p2_keys, m_p2);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
